tcounter_mod: RTL and testbench
===============================

Name: tcounter_mod

Overview:
- Parametrised synchronous modulo up/down counter built from toggle-enable semantics.
- Generalises the single T flip-flop to a WIDTH-bit counter with modulus, direction, parallel load, cascade carry and a sticky overflow flag.
- Used as the counting primitive for the lab counter/timer blocks.
- Cascadable: the TC output of one stage drives the EN input of the next.

Parameters:
- WIDTH, 4, counter width in bits; legal range 1..16.
- MOD, 10, count modulus; Q ranges 0..MOD-1; legal range 2..2**WIDTH.

Ports:
- CLK  in  1  clock, rising edge active
- RST  in  1  asynchronous active-low reset
- EN  in  1  count enable (toggle enable); step by one when high
- UP  in  1  direction: 1 = count up, 0 = count down
- LD  in  1  synchronous parallel load strobe
- D  in  WIDTH  load value
- CLR_OVF  in  1  synchronous clear of the OVF flag
- Q  out  WIDTH  current count, registered
- TC  out  1  terminal count / carry, combinational
- OVF  out  1  sticky wrap flag, registered

Behaviour:
- Reset: RST low clears Q and OVF to 0 immediately, independent of CLK. Reset mid-count aborts the count with no further effect. Counting resumes on the first rising CLK edge after RST returns high.
- Priority at each rising edge: LD, then EN, then hold.
- LD=1:
  - Q <= D if D < MOD, otherwise Q <= 0.
  - EN and UP are ignored in that cycle.
  - OVF is unaffected by LD.
- LD=0, EN=1, UP=1:
  - Q <= Q+1 if Q != MOD-1.
  - Q <= 0 (wrap) if Q == MOD-1.
- LD=0, EN=1, UP=0:
  - Q <= Q-1 if Q != 0.
  - Q <= MOD-1 (wrap) if Q == 0.
- LD=0, EN=0: Q holds.
- Latency: one cycle from the EN/LD sample edge to the Q update.
- TC = EN & ~LD & ((UP & Q==MOD-1) | (~UP & Q==0)).
  - Purely combinational, no register.
  - High exactly in the cycle before a wrap edge, so a downstream stage's EN can be driven directly from it.
- OVF:
  - Set at any edge where a wrap occurs.
  - Cleared at an edge with CLR_OVF=1 and no wrap.
  - Set wins when wrap and CLR_OVF coincide.
- Direction change mid-count: takes effect at the next edge; TC re-evaluates combinationally.
- Arithmetic is performed in WIDTH bits. Q never leaves 0..MOD-1, including when MOD = 2**WIDTH (natural binary wrap).
- WIDTH=1, MOD=2 with UP=1 behaves as a plain T flip-flop with carry out.

Optional Feature:
- Macro: TCOUNTER_SAT_EN.
- Defined (saturating mode):
  - Up count at MOD-1 holds at MOD-1; down count at 0 holds at 0.
  - TC keeps the same equation.
  - OVF sets on every attempted step past a bound.
- Undefined: modulo wrap as specified above.
- Both builds have identical ports.

Test Plan (WIDTH=4, MOD=10 unless noted):
- Async reset: counter at Q=7, pull RST low between clock edges -> Q=0 and OVF=0 before the next rising edge; RST high and EN=1,UP=1 -> Q=1 after the first edge.
- Up wrap: EN=1, UP=1 from Q=0 for 10 edges -> Q sequence 1..9, then 0. TC high only while Q=9. OVF goes 0->1 on the wrap edge and stays 1 until CLR_OVF; CLR_OVF pulse -> OVF=0 next edge.
- Down wrap and direction flip: Q=1, UP=0, EN=1 -> Q=0 (TC=1), then Q=9 with OVF=1. Set UP=1 at Q=9 -> TC=1 combinationally, next edge Q=0.
- Load priority and range: LD=1, EN=1, D=5 -> Q=5. Then LD=1, D=12 -> Q=0. OVF unchanged across both loads.
- Simultaneous wrap and clear: Q=9, UP=1, EN=1, CLR_OVF=1 -> Q=0 and OVF=1.
- Cascade and saturation:
  - Two instances, second EN driven by first TC, EN=1 for 25 edges -> {Q_hi,Q_lo}=2,5.
  - TCOUNTER_SAT_EN build: 12 up steps from 0 -> Q=9 held, OVF=1.

Source files
------------

// File: rtl/tcounter_mod.sv
// tcounter_mod: WIDTH-bit modulo-MOD up/down counter with parallel load, cascade carry (TC) and sticky OVF.
// Define TCOUNTER_SAT_EN to saturate at 0 / MOD-1 instead of wrapping; ports are identical in both builds.
module tcounter_mod #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  input  logic             CLR_OVF,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             OVF
);
  localparam logic [WIDTH-1:0] TOP   = WIDTH'(MOD - 1);
  localparam logic [31:0]      MOD_U = 32'(MOD);

`ifdef TCOUNTER_SAT_EN
  localparam logic [WIDTH-1:0] PAST_TOP = TOP;
  localparam logic [WIDTH-1:0] PAST_BOT = '0;
`else
  localparam logic [WIDTH-1:0] PAST_TOP = '0;
  localparam logic [WIDTH-1:0] PAST_BOT = TOP;
`endif

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             at_top, at_bot, step, d_in_range;

  assign at_top = (count_q == TOP);
  assign at_bot = (count_q == '0);
  assign step   = EN & ~LD;
  assign TC     = step & ((UP & at_top) | (~UP & at_bot));

  // D is zero-extended so the range check also holds when MOD = 2**WIDTH
  assign d_in_range = ({{(32-WIDTH){1'b0}}, D} < MOD_U);

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (LD) begin
      count_d = d_in_range ? D : '0;
    end else if (EN) begin
      if (UP) begin
        count_d = at_top ? PAST_TOP : count_q + WIDTH'(1);
      end else begin
        count_d = at_bot ? PAST_BOT : count_q - WIDTH'(1);
      end
    end
    // TC marks exactly the edges that step past a bound, so it doubles as the OVF set term
    if (TC) begin
      ovf_d = 1'b1;
    end else if (CLR_OVF) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Q   = count_q;
  assign OVF = ovf_q;
endmodule

// File: tb/tb_tcounter_mod.sv
// Bench for tcounter_mod: vector table plus hand sequences for reset, direction flip, cascade,
// T flip-flop / full-binary instances and the 12-step saturation/wrap run; scoreboard queue holds expectations.
module tb_tcounter_mod;
  localparam int M = 10;
`ifdef TCOUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int WU = SAT ? M - 1 : 0;
  localparam int WD = SAT ? 0 : M - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en, up, ld, clr;
  logic [3:0] d;
  logic [3:0] q;
  logic       tc, ovf;

  logic       c_en;
  logic [3:0] lo_q, hi_q;
  logic       lo_tc, lo_ovf, hi_tc, hi_ovf;

  logic       b_en, b_up;
  logic [0:0] t_q;
  logic       t_tc, t_ovf;
  logic [3:0] m_q;
  logic       m_tc, m_ovf;

  always #5 clk = ~clk;

  tcounter_mod #(.WIDTH(4), .MOD(10)) dut (
    .CLK(clk), .RST(rst_n), .EN(en), .UP(up), .LD(ld), .D(d), .CLR_OVF(clr),
    .Q(q), .TC(tc), .OVF(ovf)
  );

  tcounter_mod #(.WIDTH(4), .MOD(10)) u_lo (
    .CLK(clk), .RST(rst_n), .EN(c_en), .UP(1'b1), .LD(1'b0), .D(4'd0), .CLR_OVF(1'b0),
    .Q(lo_q), .TC(lo_tc), .OVF(lo_ovf)
  );

  tcounter_mod #(.WIDTH(4), .MOD(10)) u_hi (
    .CLK(clk), .RST(rst_n), .EN(lo_tc), .UP(1'b1), .LD(1'b0), .D(4'd0), .CLR_OVF(1'b0),
    .Q(hi_q), .TC(hi_tc), .OVF(hi_ovf)
  );

  tcounter_mod #(.WIDTH(1), .MOD(2)) u_tff (
    .CLK(clk), .RST(rst_n), .EN(b_en), .UP(b_up), .LD(1'b0), .D(1'b0), .CLR_OVF(1'b0),
    .Q(t_q), .TC(t_tc), .OVF(t_ovf)
  );

  tcounter_mod #(.WIDTH(4), .MOD(16)) u_m16 (
    .CLK(clk), .RST(rst_n), .EN(b_en), .UP(b_up), .LD(1'b0), .D(4'd0), .CLR_OVF(1'b0),
    .Q(m_q), .TC(m_tc), .OVF(m_ovf)
  );

  typedef struct {
    logic       en, up, ld;
    logic [3:0] d;
    logic       clr;
    logic       tc;
    int         q;
    logic       ovf;
  } vec_t;

  typedef struct {
    string name;
    int    q;
    int    ovf;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input string name, input int q_e, input int ovf_e);
    exp_t e;
    e.name = name;
    e.q    = q_e;
    e.ovf  = ovf_e;
    sb.push_back(e);
  endtask

  task automatic pop_compare(input int act_q, input int act_ovf);
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: got output with no expectation queued");
    end else begin
      e = sb.pop_front();
      check({e.name, " q"}, act_q, e.q);
      check({e.name, " ovf"}, act_ovf, e.ovf);
      $display("txn %s: q=%0d ovf=%0d (exp q=%0d ovf=%0d)", e.name, act_q, act_ovf, e.q, e.ovf);
    end
  endtask

  function automatic void add(input logic en_i, input logic up_i, input logic ld_i,
                              input logic [3:0] d_i, input logic clr_i,
                              input logic tc_i, input int q_i, input logic ovf_i);
    vec_t v;
    v.en = en_i; v.up = up_i; v.ld = ld_i; v.d = d_i; v.clr = clr_i;
    v.tc = tc_i; v.q = q_i; v.ovf = ovf_i;
    vecs.push_back(v);
  endfunction

  task automatic apply(input string name, input logic en_i, input logic up_i, input logic ld_i,
                       input logic [3:0] d_i, input logic clr_i,
                       input logic tc_e, input int q_e, input logic ovf_e);
    @(negedge clk);
    en = en_i; up = up_i; ld = ld_i; d = d_i; clr = clr_i;
    #1;
    check({name, " tc"}, int'(tc), int'(tc_e));
    push_exp(name, q_e, int'(ovf_e));
    @(posedge clk);
    #1;
    pop_compare(int'(q), int'(ovf));
  endtask

  function automatic int model_next(input int cur, input int mod, input bit dir_up);
    if (dir_up) return (cur == mod - 1) ? (SAT ? cur : 0) : cur + 1;
    return (cur == 0) ? (SAT ? 0 : mod - 1) : cur - 1;
  endfunction

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    en = 0; up = 0; ld = 0; d = 4'd0; clr = 0; c_en = 0; b_en = 0; b_up = 1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset q", int'(q), 0);
    check("reset ovf", int'(ovf), 0);
    check("reset tc", int'(tc), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // en, up, ld, d, clr | tc before edge, q and ovf after edge
    add(1, 1, 1, 4'd0, 0,   0, 0, 0);
    for (int i = 1; i <= 9; i++) add(1, 1, 0, 4'd0, 0,   0, i, 0);
    add(1, 1, 0, 4'd0, 0,   1, WU, 1);
    add(0, 1, 1, 4'd0, 0,   0, 0, 1);
    add(0, 0, 0, 4'd0, 0,   0, 0, 1);
    add(0, 0, 0, 4'd0, 1,   0, 0, 0);
    add(0, 0, 1, 4'd1, 0,   0, 1, 0);
    add(1, 0, 0, 4'd0, 0,   0, 0, 0);
    add(1, 0, 0, 4'd0, 0,   1, WD, 1);
    add(0, 0, 1, 4'd9, 1,   0, 9, 0);
    add(1, 0, 0, 4'd0, 0,   0, 8, 0);
    add(0, 1, 1, 4'd9, 0,   0, 9, 0);
    add(1, 1, 0, 4'd0, 0,   1, WU, 1);
    add(1, 1, 1, 4'd5, 0,   0, 5, 1);
    add(1, 1, 1, 4'd12, 0,  0, 0, 1);
    add(0, 1, 1, 4'd10, 0,  0, 0, 1);
    add(0, 1, 1, 4'd9, 1,   0, 9, 0);
    add(1, 1, 0, 4'd0, 1,   1, WU, 1);
    add(0, 1, 1, 4'd9, 1,   0, 9, 0);
    add(1, 1, 1, 4'd3, 0,   0, 3, 0);
    add(1, 0, 1, 4'd15, 0,  0, 0, 0);
    add(1, 0, 0, 4'd0, 0,   1, WD, 1);

    for (int i = 0; i < vecs.size(); i++)
      apply($sformatf("v%0d", i), vecs[i].en, vecs[i].up, vecs[i].ld, vecs[i].d, vecs[i].clr,
            vecs[i].tc, vecs[i].q, vecs[i].ovf);

    // direction flip at Q=9: TC follows UP within the same cycle
    apply("flip_ld9", 0, 0, 1, 4'd9, 1, 0, 9, 0);
    @(negedge clk);
    en = 1; up = 0; ld = 0; clr = 0;
    #1;
    check("flip tc down", int'(tc), 0);
    up = 1;
    #1;
    check("flip tc up", int'(tc), 1);
    push_exp("flip", WU, 1);
    @(posedge clk);
    #1;
    pop_compare(int'(q), int'(ovf));

    // asynchronous reset between edges, held across an enabled edge, then resume
    apply("rst_ld7", 0, 1, 1, 4'd7, 0, 0, 7, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async q", int'(q), 0);
    check("async ovf", int'(ovf), 0);
    en = 1; up = 1; ld = 0;
    @(posedge clk);
    #1;
    check("rst hold q", int'(q), 0);
    en = 0;
    rst_n = 1'b1;
    apply("rst_resume", 1, 1, 0, 4'd0, 0, 0, 1, 0);

    // 12 up steps from 0: wraps to 2 in the default build, pins at 9 when saturating
    apply("s_ld0", 0, 1, 1, 4'd0, 1, 0, 0, 0);
    for (int i = 1; i <= 12; i++)
      apply($sformatf("s%0d", i), 1, 1, 0, 4'd0, 0,
            SAT ? (i - 1 >= 9) : ((i - 1) % 10 == 9),
            SAT ? ((i < 9) ? i : 9) : i % 10,
            i >= 10);
    check("twelve steps q", int'(q), SAT ? 9 : 2);

    // two-stage cascade, upper EN driven by lower TC
    check("cascade start", int'({hi_q, lo_q}), 0);
    for (int n = 1; n <= 25; n++) begin
      int lo_e, hi_e, prev_lo;
      prev_lo = SAT ? ((n - 1 < 9) ? n - 1 : 9) : (n - 1) % 10;
      lo_e = SAT ? ((n < 9) ? n : 9) : n % 10;
      hi_e = SAT ? ((n <= 9) ? 0 : ((n - 9 < 9) ? n - 9 : 9)) : (n / 10) % 10;
      @(negedge clk);
      c_en = 1;
      #1;
      check($sformatf("cas%0d lo_tc", n), int'(lo_tc), int'(prev_lo == 9));
      push_exp($sformatf("cas%0d", n), hi_e * 16 + lo_e, int'(n >= 10));
      @(posedge clk);
      #1;
      pop_compare(int'({hi_q, lo_q}), int'(lo_ovf));
    end
    @(negedge clk);
    c_en = 0;
    check("cascade final", int'({hi_q, lo_q}), SAT ? 8'h99 : 8'h25);

    // WIDTH=1/MOD=2 T flip-flop and full-binary MOD=16 instances stepping together
    begin
      int tq, mq, mo;
      tq = 0; mq = 0; mo = 0;
      for (int s = 0; s < 21; s++) begin
        bit dir;
        dir = (s < 18);
        @(negedge clk);
        b_en = 1; b_up = dir;
        #1;
        check($sformatf("bin%0d t_tc", s), int'(t_tc), int'(dir ? tq == 1 : tq == 0));
        check($sformatf("bin%0d m_tc", s), int'(m_tc), int'(dir ? mq == 15 : mq == 0));
        if (dir ? mq == 15 : mq == 0) mo = 1;
        tq = model_next(tq, 2, dir);
        mq = model_next(mq, 16, dir);
        push_exp($sformatf("bin%0d", s), mq * 2 + tq, mo);
        @(posedge clk);
        #1;
        pop_compare(int'({m_q, t_q}), int'(m_ovf));
      end
      @(negedge clk);
      b_en = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
